// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing types: the default 640x480@60 mode and the axis-length helper.
package vga_pkg;

    typedef struct packed {
        int   h_active;
        int   h_front;
        int   h_sync;
        int   h_back;
        int   v_active;
        int   v_front;
        int   v_sync;
        int   v_back;
        logic h_pol;
        logic v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_active: 480, v_front: 10, v_sync: 2,  v_back: 33,
        h_pol: 1'b0,   v_pol: 1'b0
    };

    function automatic int total(input int active, input int front,
                                 input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping counter plus active/sync region decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter  int ACTIVE = 640,
    parameter  int FRONT  = 16,
    parameter  int SYNC   = 96,
    parameter  int BACK   = 48,
    localparam int TOTAL  = total(ACTIVE, FRONT, SYNC, BACK),
    localparam int W      = $clog2(TOTAL)
) (
    input  logic         pixel_clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);

    // One extra bit so a sync region ending exactly at TOTAL (zero back porch)
    // still has a representable bound.
    localparam logic [W:0] LAST     = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FRONT);
    localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FRONT + SYNC);

    logic [W:0] cnt_x;

    assign cnt_x     = {1'b0, cnt};
    assign wrap      = inc && (cnt_x == LAST);
    assign in_active = cnt_x < ACT_END;
    assign in_sync   = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc)
            cnt <= wrap ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V axis counters, sync/de/strobe decode and a
// PIPE_DELAY register pipeline so every output shares the same latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter  int   H_ACTIVE   = VGA_640x480_60.h_active,
    parameter  int   H_FRONT    = VGA_640x480_60.h_front,
    parameter  int   H_SYNC     = VGA_640x480_60.h_sync,
    parameter  int   H_BACK     = VGA_640x480_60.h_back,
    parameter  int   V_ACTIVE   = VGA_640x480_60.v_active,
    parameter  int   V_FRONT    = VGA_640x480_60.v_front,
    parameter  int   V_SYNC     = VGA_640x480_60.v_sync,
    parameter  int   V_BACK     = VGA_640x480_60.v_back,
    parameter  logic H_SYNC_POL = VGA_640x480_60.h_pol,
    parameter  logic V_SYNC_POL = VGA_640x480_60.v_pol,
    parameter  int   PIPE_DELAY = 1,
    localparam int   H_TOTAL    = total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
    localparam int   V_TOTAL    = total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
    localparam int   X_W        = $clog2(H_TOTAL),
    localparam int   Y_W        = $clog2(V_TOTAL)
) (
    input  logic           pixel_clk,
    input  logic           rst_n,
    input  logic           en,
    output logic           h_sync,
    output logic           v_sync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    typedef struct packed {
        logic           h_sync;
        logic           v_sync;
        logic           de;
        logic           line_start;
        logic           frame_start;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } tap_t;

    localparam tap_t IDLE = '{
        h_sync: ~H_SYNC_POL, v_sync: ~V_SYNC_POL, de: 1'b0,
        line_start: 1'b0, frame_start: 1'b0, x: '0, y: '0
    };

    logic [X_W-1:0] hc;
    logic [Y_W-1:0] vc;
    logic           h_wrap, v_wrap;
    logic           h_act, v_act, h_in_sync, v_in_sync;
    logic           at_line, at_frame;
    tap_t           head;
    tap_t           stg [PIPE_DELAY];

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .inc(en),
        .cnt(hc), .wrap(h_wrap), .in_active(h_act), .in_sync(h_in_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .inc(h_wrap),
        .cnt(vc), .wrap(v_wrap), .in_active(v_act), .in_sync(v_in_sync)
    );

    // Flags tracking "counter sits at x==0" / "at (0,0)": set out of reset and
    // by the wrap that lands there, cleared by any other enabled step.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            at_line  <= 1'b1;
            at_frame <= 1'b1;
        end else if (en) begin
            at_line  <= h_wrap;
            at_frame <= v_wrap;
        end
    end

    always_comb begin
        head             = IDLE;
        head.h_sync      = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
        head.v_sync      = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
        head.de          = h_act && v_act;
        head.line_start  = at_line;
        head.frame_start = at_frame;
        head.x           = hc;
        head.y           = vc;
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) stg[i] <= IDLE;
        end else if (en) begin
            stg[0] <= head;
            for (int i = 1; i < PIPE_DELAY; i++) stg[i] <= stg[i-1];
        end
    end

    assign h_sync      = stg[PIPE_DELAY-1].h_sync;
    assign v_sync      = stg[PIPE_DELAY-1].v_sync;
    assign de          = stg[PIPE_DELAY-1].de;
    assign line_start  = stg[PIPE_DELAY-1].line_start;
    assign frame_start = stg[PIPE_DELAY-1].frame_start;
    assign x           = stg[PIPE_DELAY-1].x;
    assign y           = stg[PIPE_DELAY-1].y;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA output path. It produces horizontal and vertical sync with configurable polarity, a data-enable flag, pixel coordinates, and line/frame start strobes, all from `pixel_clk`. Every output passes through a configurable register pipeline so sync and data-enable line up with downstream pixel pipelines. It replaces fixed-constant counters in the top level and feeds the sync pins, LEDs and any pixel source.

## Interface
- `H_ACTIVE`, 640: visible pixels per line (≥1)
- `H_FRONT`, 16: horizontal front porch, in pixels (≥0)
- `H_SYNC`, 96: horizontal sync width, in pixels (≥1)
- `H_BACK`, 48: horizontal back porch, in pixels (≥0)
- `V_ACTIVE`, 480: visible lines per frame (≥1)
- `V_FRONT`, 10: vertical front porch, in lines (≥0)
- `V_SYNC`, 2: vertical sync width, in lines (≥1)
- `V_BACK`, 33: vertical back porch, in lines (≥0)
- `H_SYNC_POL`, 1'b0: asserted level of `h_sync` (0 = negative)
- `V_SYNC_POL`, 1'b0: asserted level of `v_sync`
- `PIPE_DELAY`, 1: register stages between counters and outputs (≥1)
- Derived values: H_TOTAL is the sum of the four H parameters; V_TOTAL likewise; X_W = $clog2(H_TOTAL); Y_W = $clog2(V_TOTAL).
- `pixel_clk`  input  1  pixel clock (25.175 MHz for 640x480@60)
- `rst_n`  input  1  asynchronous, active-low reset
- `en`  input  1  count enable; low freezes the entire block
- `h_sync`  output  1  horizontal sync, at `H_SYNC_POL` when asserted
- `v_sync`  output  1  vertical sync, at `V_SYNC_POL` when asserted
- `de`  output  1  high while x < H_ACTIVE and y < V_ACTIVE
- `x`  output  X_W  horizontal counter value, 0..H_TOTAL-1
- `y`  output  Y_W  vertical counter value, 0..V_TOTAL-1
- `line_start`  output  1  one-cycle strobe when x == 0
- `frame_start`  output  1  one-cycle strobe when x == 0 and y == 0

## Operation
- Line layout: active, then front porch, then sync, then back porch.
  - `h_sync` is asserted for H_ACTIVE+H_FRONT ≤ x < H_ACTIVE+H_FRONT+H_SYNC.
  - The vertical layout is the same, using y and the V parameters.
- Counters `hc` and `vc`:
  - On `en`, `hc` increments. It wraps to 0 after H_TOTAL-1.
  - On `hc` wrap, `vc` increments. It wraps to 0 after V_TOTAL-1.
  - Both wrap on the same edge at (H_TOTAL-1, V_TOTAL-1).
- `v_sync` and vertical `de` change only at the x == 0 boundary, because they are decoded from `vc`.
- `x` and `y` are raw counter values and are not clamped during blanking; qualify them with `de`.
- `en` low: counters and every pipeline stage hold their value.
  - Outputs stay static, so a strobe that was high stays high until `en` returns.
  - Downstream logic qualifies strobes with `en`.
- Zero-length porches are legal. Sync then starts immediately after active, or active starts immediately after sync.

## Timing
- Reset (async assert, sync-to-clock release is the top level's responsibility):
  - `hc` and `vc` are 0.
  - All pipeline stages are idle: `h_sync` = ~H_SYNC_POL, `v_sync` = ~V_SYNC_POL, `de` = 0, `x` = 0, `y` = 0, `line_start` = 0, `frame_start` = 0.
- Latency: every output reflects the counter state from exactly PIPE_DELAY enabled cycles earlier. All outputs share the same delay.
- First frame: PIPE_DELAY enabled cycles after reset release, outputs show (0,0) with `de` = 1, `line_start` = 1 and `frame_start` = 1.
- Periods: line = H_TOTAL cycles, frame = H_TOTAL×V_TOTAL enabled cycles. With defaults these are 800 and 420 000.
- Reset asserted mid-frame: outputs go to reset values immediately. Restart follows the first-frame rule, with no partial-frame strobes.
- All outputs are registered and glitch-free. They can drive pins directly.

## Structure
- Package `vga_pkg`:
  - Struct `vga_timing_t` with fields h/v active, front, sync, back, and polarity.
  - Constant `VGA_640x480_60` holding the default values.
  - Function `total()`.
- Sub-module `vga_axis_counter`, instantiated twice (H and V):
  - Parameters: ACTIVE, FRONT, SYNC, BACK.
  - Inputs: `inc`.
  - Outputs: `cnt`, `wrap`, `in_active`, `in_sync`.
- The top block holds the polarity mapping, strobe decode and the PIPE_DELAY shift pipeline.

## Test plan
- Reset: hold `rst_n` low across edges. All outputs are at reset values; with defaults `h_sync` = 1 and `v_sync` = 1. Release, then after 1 cycle: x = 0, y = 0, `de` = 1, `frame_start` = 1.
- Defaults, one full frame:
  - `h_sync` is low for exactly 96 cycles, starting at x = 656, every 800 cycles.
  - `v_sync` is low for lines 490–491.
  - `de` is high for exactly 307 200 cycles.
  - `frame_start` pulses once per 420 000 cycles.
- Tiny mode (H 4/0/1/1, V 2/1/1/0, both polarities 1):
  - H_TOTAL = 6 and V_TOTAL = 4.
  - `h_sync` is high exactly at x = 4.
  - x wraps 5→0 and y wraps 3→0 on the same edge.
  - `frame_start` repeats every 24 cycles.
- `en` dropped for 10 cycles at x = 100, y = 7: all outputs are frozen at those values. On re-enable x continues at 101, and the frame period stretches by exactly 10.
- PIPE_DELAY = 3: every output is delayed by 3 cycles relative to PIPE_DELAY = 1 behaviour, and `h_sync`, `de` and `x` stay mutually aligned.
- `rst_n` pulsed low at x = 300, y = 200: outputs reset asynchronously, before the next edge. After release, the next `frame_start` occurs 1 cycle later, with no `v_sync` from the aborted frame.
